// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package adder_pkg;

    // Controller states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest operand the adder is intended to handle.
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from two half adders and an OR gate.
// This is the only arithmetic logic in the serial adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    // Only one of the two half adders can generate a carry at a time.
    assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per
// clock, LSB first, through a single full-adder cell.
// Optional feature macro: SERIAL_ADDER_OVF_EN (registered signed overflow
// flag); when undefined the ovf port is tied low.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_reg;
    state_e           state_next;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] work_next;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             fa_s;
    logic             fa_co;

    // Operands are shifted right each RUN cycle, so bit 0 is always the
    // bit currently being added.
    full_adder_cell u_fa (
        .a   (a_reg[0]),
        .b   (b_reg[0]),
        .cin (carry_reg),
        .s   (fa_s),
        .co  (fa_co)
    );

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    // Result bits enter at the MSB end; after WIDTH shifts the LSB has
    // reached bit 0, so work_next on the last bit is the complete sum.
    generate
        if (WIDTH == 1) begin : g_work_w1
            assign work_next = fa_s;
        end else begin : g_work_wn
            assign work_next = {fa_s, work_reg[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the current state.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            work_reg  <= '0;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            carry_reg <= fa_co;
            work_reg  <= work_next;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (last_bit) begin
                sum_reg  <= work_next;
                cout_reg <= fa_co;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // On the last bit carry_reg is the carry into the MSB; signed overflow
    // is that carry disagreeing with the carry out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_bit) begin
            ovf_reg <= carry_reg ^ fa_co;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule
